rgb_to_hsv_stream: RTL and testbench



---
 rtl/rgb2hsv_pkg.sv | 23 ++
 rtl/hsv_pipe_div.sv | 86 ++++++++
 rtl/rgb_to_hsv_stream.sv | 220 ++++++++++++++++++++++
 tb/tb_rgb_to_hsv_stream.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb2hsv_pkg.sv
// Shared constants, sector encoding and latency helper for the RGB-to-HSV stream converter.
package rgb2hsv_pkg;

  localparam int unsigned HUE_W      = 9;
  localparam int unsigned HUE_SECTOR = 60;
  localparam int unsigned HUE_MAX    = 360;

  localparam int unsigned HUE_BASE_R = 0;
  localparam int unsigned HUE_BASE_G = 120;
  localparam int unsigned HUE_BASE_B = 240;

  typedef enum logic [1:0] {
    SEC_R,
    SEC_G,
    SEC_B
  } sector_t;

  // Stage 1 + stage 2 + COMP_W divider stages + output register.
  function automatic int unsigned rgb2hsv_latency(input int unsigned comp_w);
    return comp_w + 32'd3;
  endfunction

endpackage

// File: rtl/hsv_pipe_div.sv
// Pipelined restoring divider: one quotient bit per stage, MSB first, all stages gated by en.
// Requires num < den * 2^Q_W so the upper numerator bits seed a remainder below den.
module hsv_pipe_div #(
  parameter int unsigned NUM_W = 14,
  parameter int unsigned DEN_W = 8,
  parameter int unsigned Q_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic [Q_W-1:0]   quo
);

  for (genvar k = 0; k < Q_W; k++) begin : g_stage
    logic [DEN_W-1:0] rem_i;
    logic [DEN_W-1:0] den_i;
    logic [Q_W-1:0]   quo_i;
    logic             cur_bit;
    logic [DEN_W:0]   trial;
    logic             ge;
    logic [Q_W-1:0]   quo_nx;
    logic [Q_W-1:0]   quo_r;

    if (k == 0) begin : g_in
      assign rem_i   = DEN_W'(num[NUM_W-1:Q_W]);
      assign den_i   = den;
      assign quo_i   = '0;
      assign cur_bit = num[Q_W-1];
    end else begin : g_chain
      assign rem_i   = g_stage[k-1].g_pass.rem_r;
      assign den_i   = g_stage[k-1].g_pass.den_r;
      assign quo_i   = g_stage[k-1].quo_r;
      assign cur_bit = g_stage[k-1].g_pass.lo_r[Q_W-1-k];
    end

    assign trial = {rem_i, cur_bit};
    assign ge    = (trial >= {1'b0, den_i});

    always_comb begin
      quo_nx = quo_i;
      if (ge) quo_nx[Q_W-1-k] = 1'b1;
    end

    always_ff @(posedge clk) begin
      if (rst) quo_r <= '0;
      else if (en) quo_r <= quo_nx;
    end

    // Remainder, divisor and unconsumed numerator bits travel on to the next stage.
    if (k < Q_W - 1) begin : g_pass
      logic [DEN_W-1:0] rem_nx;
      logic [DEN_W-1:0] rem_r;
      logic [DEN_W-1:0] den_r;
      logic [Q_W-2-k:0] lo_i;
      logic [Q_W-2-k:0] lo_r;

      if (k == 0) begin : g_lo0
        assign lo_i = num[Q_W-2:0];
      end else begin : g_lon
        assign lo_i = g_stage[k-1].g_pass.lo_r[Q_W-2-k:0];
      end

      always_comb begin
        rem_nx = trial[DEN_W-1:0];
        if (ge) rem_nx = DEN_W'(trial - {1'b0, den_i});
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rem_r <= '0;
          den_r <= '0;
          lo_r  <= '0;
        end else if (en) begin
          rem_r <= rem_nx;
          den_r <= den_i;
          lo_r  <= lo_i;
        end
      end
    end
  end

  assign quo = g_stage[Q_W-1].quo_r;

endmodule

// File: rtl/rgb_to_hsv_stream.sv
// Fully pipelined RGB-to-HSV converter with valid/ready on both sides and a sideband field.
// Define RGB2HSV_ROUND_EN for round-half-up division instead of truncation.
module rgb_to_hsv_stream
  import rgb2hsv_pkg::*;
#(
  parameter int unsigned COMP_W = 8,
  parameter int unsigned USER_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COMP_W-1:0] in_r,
  input  logic [COMP_W-1:0] in_g,
  input  logic [COMP_W-1:0] in_b,
  input  logic [USER_W-1:0] in_user,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HUE_W-1:0]  out_h,
  output logic [COMP_W-1:0] out_s,
  output logic [COMP_W-1:0] out_v,
  output logic [USER_W-1:0] out_user
);

  localparam int unsigned DIV_ST = rgb2hsv_latency(COMP_W) - 32'd3;
  localparam int unsigned HNUM_W = COMP_W + 6;
  localparam int unsigned SNUM_W = 2 * COMP_W;
  localparam logic [COMP_W-1:0] CMAX = '1;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1: max/min, delta and dominant sector (R > G > B on ties).
  logic [COMP_W-1:0] max_c, min_c;
  sector_t           sec_c;

  always_comb begin
    sec_c = SEC_R;
    max_c = in_r;
    if (in_r >= in_g && in_r >= in_b) begin
      sec_c = SEC_R;
      max_c = in_r;
    end else if (in_g >= in_b) begin
      sec_c = SEC_G;
      max_c = in_g;
    end else begin
      sec_c = SEC_B;
      max_c = in_b;
    end
    min_c = in_r;
    if (in_g < min_c) min_c = in_g;
    if (in_b < min_c) min_c = in_b;
  end

  logic              s1_valid;
  logic [COMP_W-1:0] s1_r, s1_g, s1_b, s1_max, s1_delta;
  sector_t           s1_sec;
  logic [USER_W-1:0] s1_user;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_max   <= '0;
      s1_delta <= '0;
      s1_sec   <= SEC_R;
      s1_user  <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_r     <= in_r;
      s1_g     <= in_g;
      s1_b     <= in_b;
      s1_max   <= max_c;
      s1_delta <= max_c - min_c;
      s1_sec   <= sec_c;
      s1_user  <= in_user;
    end
  end

  // Stage 2: hue/saturation numerators, hue sign and sector base.
  logic [COMP_W:0]   diff;
  logic              neg_c;
  logic [COMP_W-1:0] mag_c;
  logic [HUE_W-1:0]  base_c;
  logic [HNUM_W-1:0] hnum_c;
  logic [SNUM_W-1:0] snum_c;

  always_comb begin
    diff   = {1'b0, s1_g} - {1'b0, s1_b};
    base_c = HUE_W'(HUE_BASE_R);
    case (s1_sec)
      SEC_G: begin
        diff   = {1'b0, s1_b} - {1'b0, s1_r};
        base_c = HUE_W'(HUE_BASE_G);
      end
      SEC_B: begin
        diff   = {1'b0, s1_r} - {1'b0, s1_g};
        base_c = HUE_W'(HUE_BASE_B);
      end
      default: ;
    endcase
    neg_c  = diff[COMP_W];
    mag_c  = neg_c ? COMP_W'(-diff) : diff[COMP_W-1:0];
    hnum_c = HNUM_W'(mag_c) * HNUM_W'(HUE_SECTOR);
    snum_c = SNUM_W'(s1_delta) * SNUM_W'(CMAX);
`ifdef RGB2HSV_ROUND_EN
    hnum_c = hnum_c + HNUM_W'(s1_delta >> 1);
    snum_c = snum_c + SNUM_W'(s1_max >> 1);
`endif
  end

  logic              s2_valid, s2_neg;
  logic [HNUM_W-1:0] s2_hnum;
  logic [SNUM_W-1:0] s2_snum;
  logic [COMP_W-1:0] s2_delta, s2_max;
  logic [HUE_W-1:0]  s2_base;
  logic [USER_W-1:0] s2_user;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_neg   <= 1'b0;
      s2_hnum  <= '0;
      s2_snum  <= '0;
      s2_delta <= '0;
      s2_max   <= '0;
      s2_base  <= '0;
      s2_user  <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_neg   <= neg_c;
      s2_hnum  <= hnum_c;
      s2_snum  <= snum_c;
      s2_delta <= s1_delta;
      s2_max   <= s1_max;
      s2_base  <= base_c;
      s2_user  <= s1_user;
    end
  end

  logic [COMP_W-1:0] q_h, q_s;

  hsv_pipe_div #(.NUM_W(HNUM_W), .DEN_W(COMP_W), .Q_W(DIV_ST)) u_hue_div (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .num (s2_hnum),
    .den (s2_delta),
    .quo (q_h)
  );

  hsv_pipe_div #(.NUM_W(SNUM_W), .DEN_W(COMP_W), .Q_W(DIV_ST)) u_sat_div (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .num (s2_snum),
    .den (s2_max),
    .quo (q_s)
  );

  // Side data delayed alongside the divider stages.
  logic [DIV_ST-1:0]             sd_valid, sd_neg, sd_zero;
  logic [DIV_ST-1:0][HUE_W-1:0]  sd_base;
  logic [DIV_ST-1:0][COMP_W-1:0] sd_max;
  logic [DIV_ST-1:0][USER_W-1:0] sd_user;

  always_ff @(posedge clk) begin
    if (rst) begin
      sd_valid <= '0;
      sd_neg   <= '0;
      sd_zero  <= '0;
      sd_base  <= '0;
      sd_max   <= '0;
      sd_user  <= '0;
    end else if (en) begin
      sd_valid <= {sd_valid[DIV_ST-2:0], s2_valid};
      sd_neg   <= {sd_neg[DIV_ST-2:0], s2_neg};
      sd_zero  <= {sd_zero[DIV_ST-2:0], (s2_delta == '0)};
      sd_base  <= {sd_base[DIV_ST-2:0], s2_base};
      sd_max   <= {sd_max[DIV_ST-2:0], s2_max};
      sd_user  <= {sd_user[DIV_ST-2:0], s2_user};
    end
  end

  // Final hue: always offset negatives by 360, then fold anything >= 360 back.
  logic [9:0] h_sum;

  always_comb begin
    if (sd_neg[DIV_ST-1])
      h_sum = 10'(sd_base[DIV_ST-1]) + 10'(HUE_MAX) - 10'(q_h);
    else
      h_sum = 10'(sd_base[DIV_ST-1]) + 10'(q_h);
    if (h_sum >= 10'(HUE_MAX)) h_sum = h_sum - 10'(HUE_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_h     <= '0;
      out_s     <= '0;
      out_v     <= '0;
      out_user  <= '0;
    end else if (en) begin
      out_valid <= sd_valid[DIV_ST-1];
      out_v     <= sd_max[DIV_ST-1];
      out_user  <= sd_user[DIV_ST-1];
      if (sd_zero[DIV_ST-1]) begin
        out_h <= '0;
        out_s <= '0;
      end else begin
        out_h <= HUE_W'(h_sum);
        out_s <= q_s;
      end
    end
  end

endmodule

// File: tb/tb_rgb_to_hsv_stream.sv
// Scoreboard bench for rgb_to_hsv_stream at COMP_W = 8, 6 and 12 against an arithmetic HSV model.
module tb_rgb_to_hsv_stream;

`ifdef RGB2HSV_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  typedef struct {
    int h;
    int s;
    int v;
    int u;
    int cyc;
    bit lat;
  } exp_t;

  logic clk;
  int   cyc;
  int   compared;
  int   mismatched;
  int   done_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int dir_r [8] = '{98, 251, 200, 78, 255, 255, 0, 255};
  int dir_g [8] = '{135, 152, 200, 85, 0, 0, 0, 255};
  int dir_b [8] = '{124, 50, 200, 255, 10, 1, 0, 0};
  int dir_h [8] = '{162, 30, 0, 238, 358, 0, 0, 60};
  int dir_s [8] = '{69, 204, 0, 177, 255, 255, 0, 255};
  int dir_v [8] = '{135, 251, 200, 255, 255, 255, 0, 255};

  function automatic void check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_w
    localparam int W    = (gi == 0) ? 8 : ((gi == 1) ? 6 : 12);
    localparam int LAT  = W + 3;
    localparam int VMAX = (1 << W) - 1;

    logic         rst, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_r, in_g, in_b, out_s, out_v;
    logic [1:0]   in_user, out_user;
    logic [8:0]   out_h;

    exp_t sb[$];
    bit   bp_on;
    bit   hold_vld;
    int   hold_h, hold_s, hold_v, hold_u;

    rgb_to_hsv_stream #(.COMP_W(W), .USER_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_r      (in_r),
      .in_g      (in_g),
      .in_b      (in_b),
      .in_user   (in_user),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_h     (out_h),
      .out_s     (out_s),
      .out_v     (out_v),
      .out_user  (out_user)
    );

    function automatic void model(input int r, input int g, input int b,
                                  output int h, output int s, output int v);
      int mx, mn, d, diff, base, q, num_h, num_s;
      mx = (r >= g && r >= b) ? r : ((g >= b) ? g : b);
      mn = (r <= g && r <= b) ? r : ((g <= b) ? g : b);
      d  = mx - mn;
      v  = mx;
      if (d == 0) begin
        h = 0;
        s = 0;
      end else begin
        if (r == mx) begin diff = g - b; base = 0;   end
        else if (g == mx) begin diff = b - r; base = 120; end
        else begin diff = r - g; base = 240; end
        num_h = 60 * ((diff < 0) ? -diff : diff);
        num_s = d * VMAX;
        if (ROUND) begin
          num_h = num_h + d / 2;
          num_s = num_s + mx / 2;
        end
        q = num_h / d;
        s = num_s / mx;
        h = (diff < 0) ? base - q : base + q;
        if (h < 0) h = h + 360;
        if (h >= 360) h = h - 360;
      end
    endfunction

    function automatic int scale(input int x);
      return (x * (1 << W)) / 256;
    endfunction

    task automatic send(input int r, input int g, input int b, input int u, input bit lat,
                        input int eh, input int es, input int ev);
      bit acc;
      exp_t e;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_r     = W'(r);
      in_g     = W'(g);
      in_b     = W'(b);
      in_user  = 2'(u);
      for (int t = 0; t < 300 && !acc; t++) begin
        @(negedge clk);
        if (in_ready) begin
          acc = 1'b1;
          e   = '{eh, es, ev, u, cyc + LAT, lat};
          sb.push_back(e);
        end
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      check($sformatf("w%0d_accept", W), int'(acc), 1);
    endtask

    task automatic send_rand(input bit lat);
      int r, g, b, h, s, v;
      r = int'($urandom_range(0, VMAX));
      g = int'($urandom_range(0, VMAX));
      b = int'($urandom_range(0, VMAX));
      if ($urandom_range(0, 5) == 0) g = r;
      if ($urandom_range(0, 7) == 0) b = g;
      model(r, g, b, h, s, v);
      send(r, g, b, int'($urandom_range(0, 3)), lat, h, s, v);
    endtask

    task automatic drain();
      for (int t = 0; t < 3000 && sb.size() != 0; t++) @(posedge clk);
      #1;
      check($sformatf("w%0d_drain_left", W), sb.size(), 0);
    endtask

    initial begin
      out_ready = 1'b1;
      forever begin
        @(posedge clk);
        #1;
        out_ready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end

    // Stimulus.
    initial begin
      int r, g, b, h, s, v;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_r     = '0;
      in_g     = '0;
      in_b     = '0;
      in_user  = '0;
      bp_on    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check($sformatf("w%0d_rst_out_valid", W), int'(out_valid), 0);
      check($sformatf("w%0d_rst_in_ready", W), int'(in_ready), 1);
      check($sformatf("w%0d_rst_out_h", W), int'(out_h), 0);
      check($sformatf("w%0d_rst_out_s", W), int'(out_s), 0);
      check($sformatf("w%0d_rst_out_v", W), int'(out_v), 0);
      check($sformatf("w%0d_rst_out_user", W), int'(out_user), 0);

      // Known-answer pixels, back to back.
      for (int i = 0; i < 8; i++) begin
        r = scale(dir_r[i]);
        g = scale(dir_g[i]);
        b = scale(dir_b[i]);
        model(r, g, b, h, s, v);
        if (W == 8 && !ROUND) begin
          h = dir_h[i];
          s = dir_s[i];
          v = dir_v[i];
        end
        send(r, g, b, i % 4, 1'b1, h, s, v);
      end
      drain();

      // Random pixels under pseudo-random backpressure with bubbles.
      bp_on = 1'b1;
      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        send_rand(1'b0);
      end
      drain();
      bp_on = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset with five pixels in flight.
      for (int i = 0; i < 5; i++) send_rand(1'b1);
      rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      check($sformatf("w%0d_midrst_out_valid", W), int'(out_valid), 0);
      check($sformatf("w%0d_midrst_in_ready", W), int'(in_ready), 1);
      for (int i = 0; i < 5; i++) send_rand(1'b1);
      drain();

      // Unstalled random traffic with exact latency.
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 4) == 0) begin
          @(posedge clk);
          #1;
        end
        send_rand(1'b1);
      end
      drain();
      done_cnt++;
    end

    // Monitor: ready rule, stall stability, in-order scoreboard.
    initial begin
      exp_t e;
      hold_vld = 1'b0;
      forever begin
        @(negedge clk);
        if (rst) begin
          hold_vld = 1'b0;
        end else begin
          check($sformatf("w%0d_in_ready", W), int'(in_ready), int'(!out_valid || out_ready));
          if (hold_vld) begin
            check($sformatf("w%0d_hold_valid", W), int'(out_valid), 1);
            check($sformatf("w%0d_hold_h", W), int'(out_h), hold_h);
            check($sformatf("w%0d_hold_s", W), int'(out_s), hold_s);
            check($sformatf("w%0d_hold_v", W), int'(out_v), hold_v);
            check($sformatf("w%0d_hold_user", W), int'(out_user), hold_u);
            hold_vld = 1'b0;
          end
          if (out_valid && !out_ready) begin
            hold_vld = 1'b1;
            hold_h   = int'(out_h);
            hold_s   = int'(out_s);
            hold_v   = int'(out_v);
            hold_u   = int'(out_user);
          end
          if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
              check($sformatf("w%0d_unexpected_output", W), 1, 0);
            end else begin
              e = sb.pop_front();
              check($sformatf("w%0d_h", W), int'(out_h), e.h);
              check($sformatf("w%0d_s", W), int'(out_s), e.s);
              check($sformatf("w%0d_v", W), int'(out_v), e.v);
              check($sformatf("w%0d_user", W), int'(out_user), e.u);
              if (e.lat) check($sformatf("w%0d_latency_cycle", W), cyc, e.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    done_cnt   = 0;
    for (int t = 0; t < 60000 && done_cnt < 3; t++) @(posedge clk);
    check("all_streams_done", done_cnt, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
